systolic_mm_engine: RTL and testbench

- Parametrised ROWS x COLS output-stationary integer systolic array with its own control FSM. Generalises the fixed 4x4 free-running array.
- Accepts a K-length stream of A-column and B-row vectors over a valid/ready handshake, skews them internally and accumulates C = A x B.
- Drains C row by row over a second valid/ready handshake.
- Sits between the operand fetch buffers and the result writeback path.

---
 rtl/systolic_pkg.sv | 76 +++++++
 rtl/systolic_mm_engine_pe.sv | 59 +++++
 rtl/systolic_mm_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and arithmetic for the systolic matrix-multiply engine.
// The optional saturating accumulate is selected by SYSTOLIC_SAT_EN.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Widest operand/accumulator the mac helper supports; two guard bits keep
    // the pre-saturation sum exact.
    localparam int unsigned MAX_DATA_W = 32;
    localparam int unsigned MAX_ACC_W  = 64;
    localparam int unsigned EXT_W      = MAX_ACC_W + 2;

    typedef struct packed {
        logic                 sat;
        logic [MAX_ACC_W-1:0] acc;
    } mac_res_t;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Extend a w-bit value to EXT_W bits, sign- or zero-extended.
    function automatic logic [EXT_W-1:0] sext(input logic [EXT_W-1:0] v,
                                              input int unsigned      w,
                                              input logic             is_signed);
        logic [EXT_W-1:0] mask;
        logic [EXT_W-1:0] r;
        mask = (EXT_W'(1) << w) - EXT_W'(1);
        r    = v & mask;
        if (is_signed && r[7'(w - 1)]) r = r | ~mask;
        return r;
    endfunction

    // acc + a*b with full-precision product, wrapped or clamped to acc_w bits.
    function automatic mac_res_t mac(input logic [MAX_ACC_W-1:0]  acc,
                                     input logic [MAX_DATA_W-1:0] a,
                                     input logic [MAX_DATA_W-1:0] b,
                                     input int unsigned           data_w,
                                     input int unsigned           acc_w,
                                     input logic                  is_signed,
                                     input logic                  sat_en);
        logic [EXT_W-1:0] a_x, b_x, acc_x, prod, sum, hi, lo, amask, val;
        logic             ovf_hi, ovf_lo;
        mac_res_t         res;
        a_x   = sext(EXT_W'(a), data_w, is_signed);
        b_x   = sext(EXT_W'(b), data_w, is_signed);
        acc_x = sext(EXT_W'(acc), acc_w, is_signed);
        prod  = a_x * b_x;
        sum   = acc_x + prod;
        amask = (EXT_W'(1) << acc_w) - EXT_W'(1);
        if (is_signed) begin
            hi     = amask >> 1;
            lo     = ~hi;
            ovf_hi = $signed(sum) > $signed(hi);
            ovf_lo = $signed(sum) < $signed(lo);
        end else begin
            hi     = amask;
            lo     = '0;
            ovf_hi = sum > hi;
            ovf_lo = 1'b0;
        end
        val = sum;
        if (sat_en && ovf_hi)      val = hi;
        else if (sat_en && ovf_lo) val = lo;
        res.sat = sat_en & (ovf_hi | ovf_lo);
        res.acc = MAX_ACC_W'(val & amask);
        return res;
    endfunction

endpackage

// File: rtl/systolic_mm_engine_pe.sv
// One processing element: forwards a right / b down and accumulates a*b.
// With SYSTOLIC_SAT_EN it also reports a saturating accumulate.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              clr,
    input  logic              en,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
`ifdef SYSTOLIC_SAT_EN
    ,
    output logic              sat_hit_c
`endif
);

`ifdef SYSTOLIC_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    mac_res_t res;
    logic     mac_unused;

    always_comb begin
        res = mac(MAX_ACC_W'(acc), MAX_DATA_W'(a_in), MAX_DATA_W'(b_in),
                  DATA_W, ACC_W, SIGNED != 0, SAT_EN);
    end

`ifdef SYSTOLIC_SAT_EN
    assign sat_hit_c  = en & ~clr & res.sat;
    assign mac_unused = |(res.acc >> ACC_W);
`else
    assign mac_unused = res.sat | (|(res.acc >> ACC_W));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            if (clr)     acc <= '0;
            else if (en) acc <= res.acc[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic matrix-multiply engine with load/flush/drain control.
// Define SYSTOLIC_SAT_EN for saturating accumulators and a sticky sat_flag output.
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned SIGNED = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [ROWS*DATA_W-1:0]    a_vec,
    input  logic [COLS*DATA_W-1:0]    b_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*ACC_W-1:0]     out_row,
    output logic [idx_w(ROWS)-1:0]    out_row_idx,
    output logic                      busy,
    output logic                      done
`ifdef SYSTOLIC_SAT_EN
    ,
    output logic                      sat_flag
`endif
);

    localparam int unsigned RIDX_W  = idx_w(ROWS);
    localparam int unsigned CNT_W   = idx_w(ROWS + COLS);
    localparam int unsigned FLUSH_N = ROWS + COLS - 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RIDX_W-1:0]   row_q, row_d;
    logic                accept, first_beat, out_hs, acc_en;
    logic                in_ready_d, out_valid_d, busy_d, done_d;
    logic [COLS*ACC_W-1:0] out_row_d;
    logic [ROWS*DATA_W-1:0] a_inj;
    logic [COLS*DATA_W-1:0] b_inj;

    logic [DATA_W-1:0]   a_h [ROWS][COLS];
    logic [DATA_W-1:0]   b_v [ROWS][COLS];
    logic [ACC_W-1:0]    acc_a [ROWS][COLS];
    logic [COLS*ACC_W-1:0] row_flat [ROWS];

    assign accept     = in_valid & in_ready;
    assign first_beat = accept & (state_q == IDLE);
    assign out_hs     = out_valid & out_ready;
    assign acc_en     = (state_q == LOAD) | (state_q == FLUSH);
    assign a_inj      = accept ? a_vec : '0;
    assign b_inj      = accept ? b_vec : '0;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_last) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_W'(FLUSH_N);
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept && in_last) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_N);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DRAIN: begin
                // The last index is kept so it stays visible alongside done.
                if (out_hs) begin
                    if (row_q == RIDX_W'(ROWS - 1)) state_d = IDLE;
                    else                            row_d   = row_q + RIDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        in_ready_d  = (state_d == IDLE) | (state_d == LOAD);
        busy_d      = state_d != IDLE;
        out_valid_d = state_d == DRAIN;
        done_d      = (state_q == DRAIN) & out_hs & (row_q == RIDX_W'(ROWS - 1));
        out_row_d   = out_row;
        if (state_d == DRAIN) out_row_d = row_flat[row_d];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_row     <= '0;
            out_row_idx <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            in_ready    <= in_ready_d;
            out_valid   <= out_valid_d;
            out_row     <= out_row_d;
            out_row_idx <= row_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Accumulator rows flattened for the drain mux
    always_comb begin
        row_flat = '{default: '0};
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                row_flat[r][c*ACC_W +: ACC_W] = acc_a[r][c];
            end
        end
    end

    // Input skew: lane i of A (and B) sees i extra register stages
    for (genvar i = 0; i < ROWS; i++) begin : g_askew
        logic [DATA_W-1:0] sr [i+1];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= i; s++) sr[s] <= '0;
            end else begin
                sr[0] <= a_inj[i*DATA_W +: DATA_W];
                for (int s = 1; s <= i; s++) sr[s] <= sr[s-1];
            end
        end
        assign a_h[i][0] = sr[i];
    end

    for (genvar j = 0; j < COLS; j++) begin : g_bskew
        logic [DATA_W-1:0] sr [j+1];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= j; s++) sr[s] <= '0;
            end else begin
                sr[0] <= b_inj[j*DATA_W +: DATA_W];
                for (int s = 1; s <= j; s++) sr[s] <= sr[s-1];
            end
        end
        assign b_v[0][j] = sr[j];
    end

`ifdef SYSTOLIC_SAT_EN
    logic [ROWS*COLS-1:0] sat_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            sat_flag <= 1'b0;
        else if (first_beat) sat_flag <= 1'b0;
        else if (|sat_hit)   sat_flag <= 1'b1;
    end
`endif

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic [DATA_W-1:0] a_nxt, b_nxt;

            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk       (clk),
                .rst       (rst),
                .a_in      (a_h[i][j]),
                .b_in      (b_v[i][j]),
                .clr       (first_beat),
                .en        (acc_en),
                .a_out     (a_nxt),
                .b_out     (b_nxt),
                .acc       (acc_a[i][j])
`ifdef SYSTOLIC_SAT_EN
                ,
                .sat_hit_c (sat_hit[i*COLS+j])
`endif
            );

            if (j < COLS - 1) begin : g_af
                assign a_h[i][j+1] = a_nxt;
            end else begin : g_ae
                logic [DATA_W-1:0] a_unused;
                assign a_unused = a_nxt;
            end

            if (i < ROWS - 1) begin : g_bf
                assign b_v[i+1][j] = b_nxt;
            end else begin : g_be
                logic [DATA_W-1:0] b_unused;
                assign b_unused = b_nxt;
            end
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed self-checking bench for systolic_mm_engine (default 4x4 plus two 2x2 variants).
module tb_systolic_mm_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_last, out_ready;
    logic [63:0]  a_vec, b_vec;
    logic         in_ready, out_valid, busy, done;
    logic [159:0] out_row;
    logic [1:0]   out_row_idx;

    logic         in_valid2, in_last2, out_ready2;
    logic [31:0]  a2, b2;
    logic         ir_u, ov_u, busy_u, done_u, ir_s, ov_s, busy_s, done_s;
    logic [79:0]  row_u;
    logic [63:0]  row_s;
    logic [0:0]   idx_u, idx_s;
`ifdef SYSTOLIC_SAT_EN
    logic         sat_flag, sat_u, sat_s;
`endif

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_mm_engine u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_row_idx(out_row_idx), .busy(busy), .done(done)
`ifdef SYSTOLIC_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    systolic_mm_engine #(.ROWS(2), .COLS(2), .DATA_W(16), .ACC_W(40), .SIGNED(0)) u_uns (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(ir_u), .in_last(in_last2),
        .a_vec(a2), .b_vec(b2), .out_valid(ov_u), .out_ready(out_ready2),
        .out_row(row_u), .out_row_idx(idx_u), .busy(busy_u), .done(done_u)
`ifdef SYSTOLIC_SAT_EN
        , .sat_flag(sat_u)
`endif
    );

    systolic_mm_engine #(.ROWS(2), .COLS(2), .DATA_W(16), .ACC_W(32), .SIGNED(1)) u_a32 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(ir_s), .in_last(in_last2),
        .a_vec(a2), .b_vec(b2), .out_valid(ov_s), .out_ready(out_ready2),
        .out_row(row_s), .out_row_idx(idx_s), .busy(busy_s), .done(done_s)
`ifdef SYSTOLIC_SAT_EN
        , .sat_flag(sat_s)
`endif
    );

    typedef struct {
        int                k;
        logic [3:0][63:0]  a;
        logic [3:0][63:0]  b;
        logic [3:0][159:0] exp;
        bit                toggle;
        int                stall_row;
        int                lat;
    } job_t;

    job_t jobs [5];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_job(input int jn);
        job_t         j;
        int           t_acc, guard, got, stall_left;
        logic [159:0] held;
        j     = jobs[jn];
        t_acc = -1;
        held  = '0;
        for (int bt = 0; bt < j.k; bt++) begin
            @(negedge clk);
            if (j.toggle && bt > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            a_vec    = j.a[bt];
            b_vec    = j.b[bt];
            in_last  = (bt == j.k - 1);
            guard    = 0;
            while (!in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check($sformatf("job%0d accept beat%0d", jn, bt), 160'(in_ready), 160'(1));
            if (t_acc < 0) t_acc = cyc + 1;
        end
        // Garbage held on the input while the engine is not ready must be ignored.
        @(negedge clk);
        in_valid = 1'b1;
        in_last  = 1'b1;
        a_vec    = 64'h7777_7777_7777_7777;
        b_vec    = 64'h5555_5555_5555_5555;
        guard    = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check($sformatf("job%0d out_valid", jn), 160'(out_valid), 160'(1));
        if (j.lat >= 0) check($sformatf("job%0d latency", jn), 160'(cyc - t_acc), 160'(j.lat));
        got        = 0;
        stall_left = 3;
        guard      = 0;
        while (got < 4 && guard < 60) begin
            if (out_valid) begin
                if (got == j.stall_row && stall_left > 0) begin
                    if (stall_left == 3) held = out_row;
                    else check($sformatf("job%0d stall hold", jn), out_row, held);
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    check($sformatf("job%0d row idx", jn), 160'(out_row_idx), 160'(got));
                    check($sformatf("job%0d row%0d", jn, got), out_row, j.exp[got]);
                    check($sformatf("job%0d done early", jn), 160'(done), 160'(0));
                    got++;
                end
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b1;
        check($sformatf("job%0d rows drained", jn), 160'(got), 160'(4));
        check($sformatf("job%0d done pulse", jn), {done, out_valid, busy, out_row_idx}, {1'b1, 1'b0, 1'b0, 2'd3});
        @(negedge clk);
        check($sformatf("job%0d done cleared", jn), 160'(done), 160'(0));
    endtask

    task automatic run_small(input int k, input logic [15:0] a16, input logic [15:0] b16,
                             input logic [39:0] exp_u, input logic [31:0] exp_s, input logic exp_sat);
        int guard;
        for (int bt = 0; bt < k; bt++) begin
            @(negedge clk);
            in_valid2 = 1'b1;
            in_last2  = (bt == k - 1);
            a2        = {2{a16}};
            b2        = {2{b16}};
            check("small in_ready", 160'({ir_u, ir_s}), 160'(2'b11));
        end
        @(negedge clk);
        in_valid2 = 1'b0;
        in_last2  = 1'b0;
        guard     = 0;
        while (!ov_u && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("small out_valid", 160'({ov_u, ov_s}), 160'(2'b11));
        for (int r = 0; r < 2; r++) begin
            check($sformatf("uns row%0d", r), 160'(row_u), 160'({2{exp_u}}));
            check($sformatf("acc32 row%0d", r), 160'(row_s), 160'({2{exp_s}}));
            check($sformatf("small idx%0d", r), 160'({idx_u, idx_s}), 160'({2{r[0]}}));
            @(negedge clk);
        end
        check("small done", 160'({done_u, done_s, ov_u, ov_s}), 160'(4'b1100));
`ifdef SYSTOLIC_SAT_EN
        check("sat_flag", 160'({sat_u, sat_s}), 160'({1'b0, exp_sat}));
`else
        check("small exp_sat unused", 160'(exp_sat & 1'b0), 160'(0));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // job 0: all-lanes a=2, b=8, K=4 -> 64 everywhere, latency ROWS+COLS+K-1
        jobs[0].k = 4; jobs[0].toggle = 0; jobs[0].stall_row = -1; jobs[0].lat = 11;
        for (int t = 0; t < 4; t++) begin
            jobs[0].a[t]   = {4{16'd2}};
            jobs[0].b[t]   = {4{16'd8}};
            jobs[0].exp[t] = {4{40'd64}};
        end
        // job 1: A = identity, B row k = 4k+j -> C equals B
        jobs[1].k = 4; jobs[1].toggle = 0; jobs[1].stall_row = -1; jobs[1].lat = -1;
        for (int t = 0; t < 4; t++) begin
            jobs[1].a[t] = '0;
            jobs[1].a[t][t*16 +: 16] = 16'd1;
            for (int c = 0; c < 4; c++) begin
                jobs[1].b[t][c*16 +: 16]   = 16'(t * 4 + c);
                jobs[1].exp[t][c*40 +: 40] = 40'(t * 4 + c);
            end
        end
        // job 2: same as job 1 with toggling in_valid and a 3-cycle stall on row 1
        jobs[2] = jobs[1];
        jobs[2].toggle = 1; jobs[2].stall_row = 1;
        // job 3: signed a=-3, b=5, K=2 -> -30
        jobs[3].k = 2; jobs[3].toggle = 0; jobs[3].stall_row = -1; jobs[3].lat = -1;
        for (int t = 0; t < 4; t++) begin
            jobs[3].a[t]   = {4{16'hFFFD}};
            jobs[3].b[t]   = {4{16'd5}};
            jobs[3].exp[t] = {4{40'hFF_FFFF_FFE2}};
        end
        // job 4: K=1, a=b=1 -> 1
        jobs[4].k = 1; jobs[4].toggle = 0; jobs[4].stall_row = -1; jobs[4].lat = -1;
        for (int t = 0; t < 4; t++) begin
            jobs[4].a[t]   = {4{16'd1}};
            jobs[4].b[t]   = {4{16'd1}};
            jobs[4].exp[t] = {4{40'd1}};
        end

        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        a_vec = '0; b_vec = '0;
        in_valid2 = 1'b0; in_last2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        check("in_ready in reset", 160'(in_ready), 160'(0));
        rst = 1'b1;
        @(negedge clk);
        check("post-reset outputs", {in_ready, busy, out_valid, done, out_row_idx, out_row},
              {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 160'd0});

        for (int jn = 0; jn < 4; jn++) run_job(jn);

        // Reset mid-LOAD after two beats aborts the job with nothing emitted.
        for (int bt = 0; bt < 2; bt++) begin
            @(negedge clk);
            in_valid = 1'b1; in_last = 1'b0;
            a_vec = {4{16'h0123}}; b_vec = {4{16'h0456}};
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("busy in LOAD", 160'(busy), 160'(1));
        rst = 1'b0;
        #1;
        check("async reset", {busy, out_valid, in_ready, done}, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready after reset", {in_ready, busy}, 2'b10);
        run_job(4);

        run_small(1, 16'hFFFF, 16'd2, 40'h1_FFFE, 32'hFFFF_FFFE, 1'b0);
`ifdef SYSTOLIC_SAT_EN
        run_small(2, 16'h8000, 16'h8000, 40'h80000000, 32'h7FFF_FFFF, 1'b1);
`else
        run_small(2, 16'h8000, 16'h8000, 40'h80000000, 32'h8000_0000, 1'b1);
`endif
        run_small(1, 16'hFFFF, 16'd2, 40'h1_FFFE, 32'hFFFF_FFFE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
